// File: rtl/lsu_axil.sv
// -----------------------------------------------------------------------------
// lsu_axil -- load/store unit for the nano_rv32i core.
//
// Accepts one access at a time over a valid/ready request port and returns a
// single-cycle response pulse. Each access is routed by address either to the
// local data RAM (byte-lane strobes, fixed read latency) or to an MMIO window
// reached through an AXI4-Lite master. Loads are lane-extracted and sign/zero
// extended. Misaligned accesses, illegal funct3 and SLVERR/DECERR responses
// complete with rsp_err_o set and zero data.
//
// Ports
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   req_valid_i / req_ready_o      request handshake (ready only while idle)
//   req_we_i, funct3_i, addr_i,
//   wdata_i                        access descriptor (store data right-aligned)
//   rsp_valid_o, rsp_rdata_o,
//   rsp_err_o                      one-cycle completion, no backpressure
//   d_we_o, d_rd_o, d_wdata_o,
//   d_rdata_i                      data RAM port
//   m_aw*, m_w*, m_b*, m_ar*, m_r* AXI4-Lite master channels
//
// All outputs are registered: the combinational block computes the value each
// output takes in the next state, and the sequential block stores it.
// -----------------------------------------------------------------------------
module lsu_axil #(
   parameter logic [31:0] MMIO_BASE = 32'h3000_0000,
   parameter logic [31:0] MMIO_MASK = 32'hFF00_0000,
   parameter int unsigned RAM_LAT   = 1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic [3:0]  d_we_o,
   output logic [3:0]  d_rd_o,
   output logic [31:0] d_wdata_o,
   input  logic [31:0] d_rdata_i,
   output logic [31:0] m_awaddr_o,
   output logic        m_awvalid_o,
   input  logic        m_awready_i,
   output logic [31:0] m_wdata_o,
   output logic [3:0]  m_wstrb_o,
   output logic        m_wvalid_o,
   input  logic        m_wready_i,
   input  logic [1:0]  m_bresp_i,
   input  logic        m_bvalid_i,
   output logic        m_bready_o,
   output logic [31:0] m_araddr_o,
   output logic        m_arvalid_o,
   input  logic        m_arready_i,
   input  logic [31:0] m_rdata_i,
   input  logic [1:0]  m_rresp_i,
   input  logic        m_rvalid_i,
   output logic        m_rready_o
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RAM      = 3'd1,
      ST_AXI_AW_W = 3'd2,
      ST_AXI_B    = 3'd3,
      ST_AXI_AR   = 3'd4,
      ST_AXI_R    = 3'd5,
      ST_RESP     = 3'd6
   } state_t;

   localparam logic [2:0] RAM_LAT_C = 3'(RAM_LAT);

   // Byte-lane strobe for an access of the given size at lane offset sh.
   function automatic logic [3:0] f_strobe(input logic [2:0] f3, input logic [1:0] sh);
      case (f3)
         3'b000, 3'b100: f_strobe = 4'b0001 << sh;
         3'b001, 3'b101: f_strobe = 4'b0011 << sh;
         3'b010:         f_strobe = 4'b1111;
         default:        f_strobe = 4'b0000;
      endcase
   endfunction

   // Store data replicated across lanes so the strobes pick the right bytes.
   function automatic logic [31:0] f_lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (f3)
         3'b000:  f_lane_wdata = {4{wd[7:0]}};
         3'b001:  f_lane_wdata = {2{wd[15:0]}};
         default: f_lane_wdata = wd;
      endcase
   endfunction

   // Misalignment or an encoding that is not valid for this direction.
   function automatic logic f_acc_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
      logic illegal;
      logic mis;
      case (f3)
         3'b000:  begin illegal = 1'b0; mis = 1'b0;  end
         3'b001:  begin illegal = 1'b0; mis = a[0];  end
         3'b010:  begin illegal = 1'b0; mis = |a;    end
         3'b100:  begin illegal = we;   mis = 1'b0;  end
         3'b101:  begin illegal = we;   mis = a[0];  end
         default: begin illegal = 1'b1; mis = 1'b0;  end
      endcase
      f_acc_err = illegal | mis;
   endfunction

   // Shift the addressed lane down and extend it to 32 bits.
   function automatic logic [31:0] f_load_ext(input logic [2:0] f3, input logic [1:0] sh,
                                              input logic [31:0] raw);
      logic [31:0] s;
      s = raw >> {sh, 3'b000};
      case (f3)
         3'b000:  f_load_ext = {{24{s[7]}}, s[7:0]};
         3'b001:  f_load_ext = {{16{s[15]}}, s[15:0]};
         3'b010:  f_load_ext = s;
         3'b100:  f_load_ext = {24'h00_0000, s[7:0]};
         3'b101:  f_load_ext = {16'h0000, s[15:0]};
         default: f_load_ext = 32'h0000_0000;
      endcase
   endfunction

   // Request-side decode, only meaningful in the accept cycle.
   logic        is_mmio_s;
   logic        acc_err_s;
   logic [3:0]  strb_s;
   logic [31:0] wdata_lane_s;

   assign is_mmio_s    = ((addr_i & MMIO_MASK) == MMIO_BASE);
   assign acc_err_s    = f_acc_err(req_we_i, funct3_i, addr_i[1:0]);
   assign strb_s       = f_strobe(funct3_i, addr_i[1:0]);
   assign wdata_lane_s = f_lane_wdata(funct3_i, wdata_i);

   // State and registered request fields.
   state_t      state_r,   state_nxt_s;
   logic        we_r,      we_nxt_s;
   logic [2:0]  funct3_r,  funct3_nxt_s;
   logic [1:0]  sh_r,      sh_nxt_s;
   logic [2:0]  cnt_r,     cnt_nxt_s;

   // Output registers.
   logic        req_ready_r, req_ready_nxt_s;
   logic        rsp_valid_r, rsp_valid_nxt_s;
   logic [31:0] rsp_rdata_r, rsp_rdata_nxt_s;
   logic        rsp_err_r,   rsp_err_nxt_s;
   logic [3:0]  d_we_r,      d_we_nxt_s;
   logic [3:0]  d_rd_r,      d_rd_nxt_s;
   logic [31:0] d_wdata_r,   d_wdata_nxt_s;
   logic [31:0] awaddr_r,    awaddr_nxt_s;
   logic        awvalid_r,   awvalid_nxt_s;
   logic [31:0] m_wdata_r,   m_wdata_nxt_s;
   logic [3:0]  wstrb_r,     wstrb_nxt_s;
   logic        wvalid_r,    wvalid_nxt_s;
   logic        bready_r,    bready_nxt_s;
   logic [31:0] araddr_r,    araddr_nxt_s;
   logic        arvalid_r,   arvalid_nxt_s;
   logic        rready_r,    rready_nxt_s;

   // Next-state and next-output computation.
   always_comb begin
      state_nxt_s     = state_r;
      we_nxt_s        = we_r;
      funct3_nxt_s    = funct3_r;
      sh_nxt_s        = sh_r;
      cnt_nxt_s       = cnt_r;
      req_ready_nxt_s = 1'b0;
      rsp_valid_nxt_s = 1'b0;
      rsp_rdata_nxt_s = 32'h0000_0000;
      rsp_err_nxt_s   = 1'b0;
      d_we_nxt_s      = 4'b0000;
      d_rd_nxt_s      = 4'b0000;
      d_wdata_nxt_s   = d_wdata_r;
      awaddr_nxt_s    = awaddr_r;
      awvalid_nxt_s   = 1'b0;
      m_wdata_nxt_s   = m_wdata_r;
      wstrb_nxt_s     = wstrb_r;
      wvalid_nxt_s    = 1'b0;
      bready_nxt_s    = 1'b0;
      araddr_nxt_s    = araddr_r;
      arvalid_nxt_s   = 1'b0;
      rready_nxt_s    = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (req_valid_i) begin
               we_nxt_s     = req_we_i;
               funct3_nxt_s = funct3_i;
               sh_nxt_s     = addr_i[1:0];
               cnt_nxt_s    = 3'd0;
               if (acc_err_s) begin
                  // Rejected without touching RAM or the bus.
                  state_nxt_s     = ST_RESP;
                  rsp_valid_nxt_s = 1'b1;
                  rsp_err_nxt_s   = 1'b1;
               end else if (is_mmio_s) begin
                  if (req_we_i) begin
                     state_nxt_s   = ST_AXI_AW_W;
                     awaddr_nxt_s  = addr_i;
                     m_wdata_nxt_s = wdata_lane_s;
                     wstrb_nxt_s   = strb_s;
                     awvalid_nxt_s = 1'b1;
                     wvalid_nxt_s  = 1'b1;
                  end else begin
                     state_nxt_s   = ST_AXI_AR;
                     araddr_nxt_s  = addr_i;
                     arvalid_nxt_s = 1'b1;
                  end
               end else begin
                  state_nxt_s   = ST_RAM;
                  d_wdata_nxt_s = wdata_lane_s;
                  if (req_we_i) begin
                     d_we_nxt_s = strb_s;
                  end else begin
                     d_rd_nxt_s = strb_s;
                  end
               end
            end else begin
               req_ready_nxt_s = 1'b1;
            end
         end

         ST_RAM: begin
            // cnt_r counts RAM cycles; the strobe cycle is cnt_r == 0, so read
            // data is valid when cnt_r reaches the RAM latency.
            if (we_r) begin
               state_nxt_s     = ST_RESP;
               rsp_valid_nxt_s = 1'b1;
            end else if (cnt_r == RAM_LAT_C) begin
               state_nxt_s     = ST_RESP;
               rsp_valid_nxt_s = 1'b1;
               rsp_rdata_nxt_s = f_load_ext(funct3_r, sh_r, d_rdata_i);
            end else begin
               cnt_nxt_s = cnt_r + 3'd1;
            end
         end

         ST_AXI_AW_W: begin
            // AW and W complete independently; each valid drops after its own handshake.
            awvalid_nxt_s = awvalid_r & ~m_awready_i;
            wvalid_nxt_s  = wvalid_r & ~m_wready_i;
            if (!awvalid_nxt_s && !wvalid_nxt_s) begin
               state_nxt_s  = ST_AXI_B;
               bready_nxt_s = 1'b1;
            end else begin
               state_nxt_s  = ST_AXI_AW_W;
            end
         end

         ST_AXI_B: begin
            if (m_bvalid_i) begin
               state_nxt_s     = ST_RESP;
               rsp_valid_nxt_s = 1'b1;
               rsp_err_nxt_s   = (m_bresp_i != 2'b00);
            end else begin
               bready_nxt_s = 1'b1;
            end
         end

         ST_AXI_AR: begin
            if (m_arready_i) begin
               state_nxt_s  = ST_AXI_R;
               rready_nxt_s = 1'b1;
            end else begin
               arvalid_nxt_s = 1'b1;
            end
         end

         ST_AXI_R: begin
            if (m_rvalid_i) begin
               state_nxt_s     = ST_RESP;
               rsp_valid_nxt_s = 1'b1;
               if (m_rresp_i != 2'b00) begin
                  rsp_err_nxt_s = 1'b1;
               end else begin
                  rsp_rdata_nxt_s = f_load_ext(funct3_r, sh_r, m_rdata_i);
               end
            end else begin
               rready_nxt_s = 1'b1;
            end
         end

         ST_RESP: begin
            state_nxt_s     = ST_IDLE;
            req_ready_nxt_s = 1'b1;
         end

         default: begin
            state_nxt_s     = ST_IDLE;
            req_ready_nxt_s = 1'b1;
         end
      endcase
   end

   // State, request and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_r     <= ST_IDLE;
         we_r        <= 1'b0;
         funct3_r    <= 3'b000;
         sh_r        <= 2'b00;
         cnt_r       <= 3'd0;
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
         rsp_err_r   <= 1'b0;
         d_we_r      <= 4'b0000;
         d_rd_r      <= 4'b0000;
         d_wdata_r   <= 32'h0000_0000;
         awaddr_r    <= 32'h0000_0000;
         awvalid_r   <= 1'b0;
         m_wdata_r   <= 32'h0000_0000;
         wstrb_r     <= 4'b0000;
         wvalid_r    <= 1'b0;
         bready_r    <= 1'b0;
         araddr_r    <= 32'h0000_0000;
         arvalid_r   <= 1'b0;
         rready_r    <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         we_r        <= we_nxt_s;
         funct3_r    <= funct3_nxt_s;
         sh_r        <= sh_nxt_s;
         cnt_r       <= cnt_nxt_s;
         req_ready_r <= req_ready_nxt_s;
         rsp_valid_r <= rsp_valid_nxt_s;
         rsp_rdata_r <= rsp_rdata_nxt_s;
         rsp_err_r   <= rsp_err_nxt_s;
         d_we_r      <= d_we_nxt_s;
         d_rd_r      <= d_rd_nxt_s;
         d_wdata_r   <= d_wdata_nxt_s;
         awaddr_r    <= awaddr_nxt_s;
         awvalid_r   <= awvalid_nxt_s;
         m_wdata_r   <= m_wdata_nxt_s;
         wstrb_r     <= wstrb_nxt_s;
         wvalid_r    <= wvalid_nxt_s;
         bready_r    <= bready_nxt_s;
         araddr_r    <= araddr_nxt_s;
         arvalid_r   <= arvalid_nxt_s;
         rready_r    <= rready_nxt_s;
      end
   end

   assign req_ready_o = req_ready_r;
   assign rsp_valid_o = rsp_valid_r;
   assign rsp_rdata_o = rsp_rdata_r;
   assign rsp_err_o   = rsp_err_r;
   assign d_we_o      = d_we_r;
   assign d_rd_o      = d_rd_r;
   assign d_wdata_o   = d_wdata_r;
   assign m_awaddr_o  = awaddr_r;
   assign m_awvalid_o = awvalid_r;
   assign m_wdata_o   = m_wdata_r;
   assign m_wstrb_o   = wstrb_r;
   assign m_wvalid_o  = wvalid_r;
   assign m_bready_o  = bready_r;
   assign m_araddr_o  = araddr_r;
   assign m_arvalid_o = arvalid_r;
   assign m_rready_o  = rready_r;

endmodule
